// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and field extraction for the branch predictor
package bp_pkg;

    localparam int PC_MAX = 64;

    function automatic int unsigned bp_weak_nt(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    function automatic int unsigned bp_weak_t(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 1);
    endfunction

    // Word-aligned PCs: bits [1:0] never take part in indexing.
    function automatic logic [PC_MAX-1:0] bp_index(input logic [PC_MAX-1:0] pc,
                                                   input int unsigned idx_bits);
        return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [PC_MAX-1:0] bp_tag(input logic [PC_MAX-1:0] pc,
                                                 input int unsigned idx_bits,
                                                 input int unsigned tag_bits);
        return (pc >> (idx_bits + 2)) & ((64'd1 << tag_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating up/down next-value for a direction counter
module bp_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr,
    input  logic         inc,
    output logic [W-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != {W{1'b1}}) ctr_next = ctr + W'(1);
        end else begin
            if (ctr != '0) ctr_next = ctr - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int TAG_BITS  = 8,
    parameter int STAT_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 flush_tbl,
    input  logic [XLEN-1:0]      if_pc,
    output logic                 pred_taken,
    output logic [XLEN-1:0]      pred_target,
    input  logic                 upd_valid,
    input  logic                 upd_is_branch,
    input  logic [XLEN-1:0]      upd_pc,
    input  logic                 upd_taken,
    input  logic [XLEN-1:0]      upd_target,
    input  logic                 upd_pred_taken,
    input  logic [XLEN-1:0]      upd_pred_target,
    output logic                 mispredict,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispred
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(bp_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(bp_weak_t(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t              tbl [ENTRIES];
    entry_t              l_e, u_e;
    logic [IDX-1:0]      l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                l_hit, u_hit;
    logic [CTR_BITS-1:0] ctr_next;

    assign l_idx = IDX'(bp_index(PC_MAX'(if_pc), IDX));
    assign l_tag = TAG_BITS'(bp_tag(PC_MAX'(if_pc), IDX, TAG_BITS));
    assign u_idx = IDX'(bp_index(PC_MAX'(upd_pc), IDX));
    assign u_tag = TAG_BITS'(bp_tag(PC_MAX'(upd_pc), IDX, TAG_BITS));

    // Lookup reads the registered table only, so a same-cycle update is not visible.
    assign l_e   = tbl[l_idx];
    assign u_e   = tbl[u_idx];
    assign l_hit = l_e.valid && (l_e.tag == l_tag);
    assign u_hit = u_e.valid && (u_e.tag == u_tag);

    assign pred_taken  = mode & l_hit & l_e.ctr[CTR_BITS-1];
    assign pred_target = pred_taken ? l_e.target : if_pc + XLEN'(4);

    assign mispredict  = upd_valid & upd_is_branch &
                         ((upd_taken != upd_pred_taken) |
                          (upd_taken & (upd_target != upd_pred_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

    bp_sat_counter #(.W(CTR_BITS)) u_ctr (
        .ctr      (u_e.ctr),
        .inc      (upd_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
        end else if (flush_tbl) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid <= 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_is_branch) begin
                if (u_hit) begin
                    tbl[u_idx].ctr <= ctr_next;
                    if (upd_taken) tbl[u_idx].target <= upd_target;
                end else if (upd_taken) begin
                    tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: WEAK_T};
                end
            end else if (u_hit) begin
                // A non-branch matched the entry: the entry was created by an aliasing PC.
                tbl[u_idx].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (upd_valid && upd_is_branch) begin
            stat_branches <= stat_branches + STAT_BITS'(1);
            if (mispredict) stat_mispred <= stat_mispred + STAT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard testbench for branch_predictor
module tb_branch_predictor;

    logic        clock, reset, mode, flush_tbl;
    logic [31:0] if_pc, pred_target;
    logic        pred_taken;
    logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, stat_branches, stat_mispred;

    branch_predictor dut (
        .clock(clock), .reset(reset), .mode(mode), .flush_tbl(flush_tbl),
        .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic        fl;
        logic [31:0] ipc;
        logic        uv;
        logic        ub;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        upt;
        logic [31:0] uptg;
    } stim_t;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q [$];
    stim_t       cur;

    // Reference model: 64 entries, 8-bit tags, 2-bit counters.
    logic        m_valid [64];
    logic [7:0]  m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    int unsigned m_br, m_mp;

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_br = 0; m_mp = 0;
    endtask

    function automatic logic m_hit(input logic [31:0] pc);
        int i;
        i = int'(pc[7:2]);
        return m_valid[i] && (m_tag[i] == pc[15:8]);
    endfunction

    function automatic logic m_pt(input logic [31:0] pc, input logic md);
        return md && m_hit(pc) && (m_ctr[int'(pc[7:2])] >= 2);
    endfunction

    function automatic logic [31:0] m_ptg(input logic [31:0] pc, input logic md);
        return m_pt(pc, md) ? m_tgt[int'(pc[7:2])] : pc + 32'd4;
    endfunction

    function automatic logic m_mp_of(input stim_t s);
        return s.uv && s.ub && ((s.ut != s.upt) || (s.ut && (s.utg != s.uptg)));
    endfunction

    task automatic m_commit(input stim_t s);
        int i;
        i = int'(s.upc[7:2]);
        if (s.uv && s.ub) begin
            m_br++;
            if (m_mp_of(s)) m_mp++;
        end
        if (s.fl) begin
            for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
        end else if (s.uv) begin
            if (s.ub) begin
                if (m_hit(s.upc)) begin
                    m_ctr[i] = s.ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                    : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                    if (s.ut) m_tgt[i] = s.utg;
                end else if (s.ut) begin
                    m_valid[i] = 1'b1; m_tag[i] = s.upc[15:8]; m_tgt[i] = s.utg; m_ctr[i] = 2;
                end
            end else if (m_hit(s.upc)) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    // Called 1 time unit after a rising edge; returns mid-cycle, away from both edges.
    task automatic apply(input stim_t s);
        cur = s;
        mode = s.m; flush_tbl = s.fl; if_pc = s.ipc;
        upd_valid = s.uv; upd_is_branch = s.ub; upd_pc = s.upc; upd_taken = s.ut;
        upd_target = s.utg; upd_pred_taken = s.upt; upd_pred_target = s.uptg;
        exp_q.push_back({m_pt(s.ipc, s.m), m_ptg(s.ipc, s.m)});
        exp_q.push_back({m_mp_of(s), s.ut ? s.utg : s.upc + 32'd4});
        #3;
    endtask

    task automatic commit();
        @(posedge clock);
        #1;
        m_commit(cur);
        upd_valid = 1'b0; flush_tbl = 1'b0;
    endtask

    function automatic stim_t lk(input logic md, input logic [31:0] pc);
        return '{m: md, fl: 1'b0, ipc: pc, uv: 1'b0, ub: 1'b0, upc: 32'h0, ut: 1'b0,
                 utg: 32'h0, upt: 1'b0, uptg: 32'h0};
    endfunction

    function automatic stim_t up(input logic md, input logic [31:0] pc, input logic br,
                                 input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                                 input logic upt, input logic [31:0] uptg);
        return '{m: md, fl: 1'b0, ipc: pc, uv: 1'b1, ub: br, upc: upc, ut: ut,
                 utg: utg, upt: upt, uptg: uptg};
    endfunction

    task automatic test_reset();
        logic [32:0] e;
        reset = 1'b0; mode = 1'b1; flush_tbl = 1'b0; if_pc = 32'h40;
        upd_valid = 1'b0; upd_is_branch = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0;
        upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
        m_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        apply(lk(1'b1, 32'h40));
        e = exp_q.pop_front(); checks++;
        if ({pred_taken, pred_target} !== e)
            begin errors++; $display("FAIL reset_pred act=%h exp=%h", {pred_taken, pred_target}, e); end
        e = exp_q.pop_front(); checks++;
        if (mispredict !== e[32])
            begin errors++; $display("FAIL reset_mispredict act=%b exp=%b", mispredict, e[32]); end
        checks++;
        if ({stat_branches, stat_mispred} !== 64'h0)
            begin errors++; $display("FAIL reset_stats act=%0d/%0d exp=0/0", stat_branches, stat_mispred); end
        commit();
    endtask

    task automatic run_rows(input string nm, input stim_t rows [$]);
        logic [32:0] e;
        foreach (rows[i]) begin
            apply(rows[i]);
            e = exp_q.pop_front(); checks++;
            if ({pred_taken, pred_target} !== e)
                begin errors++; $display("FAIL %s[%0d] pred act=%h exp=%h", nm, i, {pred_taken, pred_target}, e); end
            e = exp_q.pop_front(); checks++;
            if ({mispredict, redirect_pc} !== e)
                begin errors++; $display("FAIL %s[%0d] resolve act=%h exp=%h", nm, i, {mispredict, redirect_pc}, e); end
            commit();
        end
        checks++;
        if (stat_branches !== m_br || stat_mispred !== m_mp)
            begin errors++; $display("FAIL %s stats act=%0d/%0d exp=%0d/%0d", nm, stat_branches, stat_mispred, m_br, m_mp); end
    endtask

    task automatic test_train();
        stim_t r [$];
        r.push_back(up(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44));
        r.push_back(lk(1'b1, 32'h40));
        run_rows("train", r);
        checks++;
        if (stat_mispred !== 32'd1)
            begin errors++; $display("FAIL train_mispred_count act=%0d exp=1", stat_mispred); end
    endtask

    task automatic test_saturation();
        stim_t r [$];
        repeat (3) r.push_back(up(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100));
        repeat (8) r.push_back(up(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0));
        r.push_back(up(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44));
        r.push_back(lk(1'b1, 32'h40));
        run_rows("saturation", r);
    endtask

    task automatic test_alias();
        stim_t r [$];
        r.push_back(up(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44));
        r.push_back(up(1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144));
        r.push_back(lk(1'b1, 32'h40));
        r.push_back(lk(1'b1, 32'h140));
        run_rows("alias", r);
    endtask

    task automatic test_same_cycle_flush_mode();
        stim_t r [$];
        stim_t f;
        r.push_back(up(1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'h240, 1'b1, 32'h200));
        r.push_back(up(1'b1, 32'h140, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h84));
        f = up(1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
        f.fl = 1'b1;
        r.push_back(f);
        r.push_back(lk(1'b1, 32'h40));
        r.push_back(lk(1'b1, 32'h140));
        r.push_back(up(1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h84));
        r.push_back(lk(1'b0, 32'h80));
        r.push_back(lk(1'b1, 32'h80));
        run_rows("same_cycle_flush_mode", r);
    endtask

    task automatic test_target_wrap();
        stim_t r [$];
        r.push_back(up(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h180, 1'b1, 32'h100));
        r.push_back(up(1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h180, 1'b1, 32'h180));
        r.push_back(up(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0));
        r.push_back(lk(1'b1, 32'h80));
        run_rows("target_wrap", r);
    endtask

    task automatic test_back_to_back();
        stim_t r [$];
        for (int i = 0; i < 12; i++) begin
            logic [31:0] pc;
            pc = {20'h0, 4'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
            r.push_back(up(1'b1, pc, 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
                           {24'h0, 8'($urandom_range(0, 255))} << 2, m_pt(pc, 1'b1), 32'h100));
        end
        run_rows("back_to_back", r);
    endtask

    task automatic test_reset_mid();
        logic [32:0] e;
        apply(up(1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304));
        e = exp_q.pop_front(); checks++;
        if ({pred_taken, pred_target} !== e)
            begin errors++; $display("FAIL reset_mid pred act=%h exp=%h", {pred_taken, pred_target}, e); end
        e = exp_q.pop_front();
        reset = 1'b0;
        @(posedge clock);
        #1;
        m_reset();
        upd_valid = 1'b0;
        reset = 1'b1;
        apply(lk(1'b1, 32'h300));
        e = exp_q.pop_front(); checks++;
        if ({pred_taken, pred_target} !== e)
            begin errors++; $display("FAIL reset_mid lookup act=%h exp=%h", {pred_taken, pred_target}, e); end
        e = exp_q.pop_front();
        checks++;
        if ({stat_branches, stat_mispred} !== 64'h0)
            begin errors++; $display("FAIL reset_mid stats act=%0d/%0d exp=0/0", stat_branches, stat_mispred); end
        commit();
    endtask

    initial begin
        test_reset();
        test_train();
        test_saturation();
        test_alias();
        test_same_cycle_flush_mode();
        test_target_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It replaces static fall-through fetch with a direct-mapped BTB and per-entry saturating direction counters.
- Lookup is combinational in IF, using the current PC.
- Training and misprediction detection happen when the resolving stage presents an outcome. The block supplies the redirect PC and the flush request for IF/ID.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 64, BTB/counter entries; must be a power of two, >=2.
- CTR_BITS, 2, direction counter width; must be >=1.
- TAG_BITS, 8, stored partial tag width; must be <= XLEN-2-log2(ENTRIES).
- STAT_BITS, 32, width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = static not-taken, 1 = dynamic prediction.
- flush_tbl  in  1  invalidate all entries.
- if_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predict taken for if_pc.
- pred_target  out  XLEN  predicted target; if_pc+4 when not taken.
- upd_valid  in  1  resolution present this cycle.
- upd_is_branch  in  1  resolved instruction is a branch or jump.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipeline.
- upd_pred_target  in  XLEN  predicted target carried down the pipeline.
- mispredict  out  1  redirect required.
- redirect_pc  out  XLEN  correct next PC.
- stat_branches  out  STAT_BITS  resolved branch count.
- stat_mispred  out  STAT_BITS  misprediction count.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - On reset assertion, all valid bits clear and every counter is set to weakly-not-taken (2^(CTR_BITS-1)-1).
  - Both stat counters go to 0.
  - Outputs after reset: pred_taken=0, pred_target=if_pc+4, mispredict=0.
  - Reset asserted mid-operation discards any pending update.
- Indexing: idx = pc[IDX+1:2] with IDX = log2(ENTRIES); tag = pc[IDX+2+TAG_BITS-1:IDX+2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] & tag match.
  - pred_taken = mode & hit & counter MSB.
  - pred_target = pred_taken ? btb_target : if_pc+4, computed modulo 2^XLEN so it wraps.
- Update (registered on the rising edge when upd_valid=1):
  - Hit and is_branch: counter saturating increment if taken, saturating decrement if not taken. It holds at 0 and at all-ones. The target is rewritten only when taken.
  - Miss, is_branch and taken: allocate the entry, overwriting any existing one. Set valid, write tag and target, set counter to weakly-taken (2^(CTR_BITS-1)).
  - Miss, is_branch and not taken: no allocation.
  - Hit and !is_branch (alias): clear valid.
  - The table trains in both modes.
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. There is no bypass.
- flush_tbl: all valid bits clear on the next edge. Counters and stats are kept. If flush_tbl and upd_valid occur together, flush wins and the update is dropped.
- mispredict (combinational) = upd_valid & upd_is_branch & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Stats, updated on upd_valid & upd_is_branch:
  - stat_branches += 1.
  - stat_mispred += mispredict.
  - Both wrap modulo 2^STAT_BITS. Neither is cleared by flush_tbl.
- Storage is flop arrays (valid, tag, target, counter), all with asynchronous reset.

Decomposition:
- Shared package (bp_pkg):
  - Counter-init constants WEAK_NT and WEAK_T as functions of CTR_BITS.
  - Index/tag extraction functions.
  - Entry struct {valid, tag, target, ctr}.
- One sub-module: bp_sat_counter, a combinational CTR_BITS-wide saturating inc/dec next-value function instantiated once in the update path.
- The hazard/flush interaction with IF/ID stays in the CPU top level.

Test Plan:
- Reset, then if_pc=0x40 with mode=1 -> pred_taken=0, pred_target=0x44, both stats 0.
- Update pc=0x40, taken, target=0x100, pred_taken=0 -> mispredict=1, redirect=0x100, stat_mispred=1. Next cycle, lookup 0x40 -> pred_taken=1, pred_target=0x100.
- Saturation with CTR_BITS=2 on pc=0x40: 3 taken updates -> counter=3. Then 1 not-taken -> still predicts taken. Then 2 more not-taken -> pred_taken=0. 5 further not-taken -> counter holds at 0 with no underflow.
- Alias: pc=0x40 and pc=0x140 with ENTRIES=64 share idx 16 with different tags. Lookup 0x140 -> miss. Update 0x140 taken to 0x200 -> the 0x40 entry is replaced and lookup 0x40 -> miss.
- Same-cycle update and lookup on 0x40, flush_tbl together with upd_valid, and mode=0 -> lookup returns the old value; flush drops the update and all entries miss; mode=0 gives pred_taken=0 while training continues.
- Target change and wrap: a hit entry for pc=0x80 predicts target 0x100, then resolves taken to 0x180 -> mispredict=1, redirect=0x180, and the stored target is updated. Also lookup if_pc=0xFFFFFFFC on a miss -> pred_target=0x0.
